mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multicycle memory-access sequencer for the datapath's load/store path. It accepts one load or store request and drives the word address to synchronous memory. It waits out the read latency, registers the returned word for the size handler mux, then either latches the size handler's result into the memory data register (loads) or issues the merged write (stores). It sits between the control unit and the size handler mux / memory pair, and is the stage that produces the `mem` operand the size handler consumes.

## Interface
- RD_WAIT, 2, cycles from address presentation to valid `mem_rdata`; legal range 1..15.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  access type: 000 sb, 001 sw, 010 sh, 011 lb, 100 lw, 101 lh; 110/111 illegal.
- addr  input  32  byte address, passed through unchanged (no alignment check).
- B  input  32  store data register value.
- mem_rdata  input  32  memory read data.
- sh_out  input  32  size handler mux output (combinational from `sh_sel`, `mem_q`, `B_q`).
- mem_addr  output  32  memory address (= latched addr).
- mem_wr  output  1  memory write enable.
- mem_wdata  output  32  write data (= `sh_out`).
- mem_q  output  32  registered memory word, feeds size handler `mem`.
- B_q  output  32  latched store data, feeds size handler `B`.
- sh_sel  output  3  size handler select (= latched op).
- mdr  output  32  load result register.
- busy  output  1  high in WAIT, CAPT, ACT.
- done  output  1  one-cycle completion pulse.
- err  output  1  high with `done` when op was illegal.

## Operation
- States: IDLE, WAIT, CAPT, ACT, DONE.
- IDLE:
  - On `start`=1, latch `op`→`sh_sel`, `addr`→`mem_addr`, `B`→`B_q`.
  - Next state: sb/sh/lb/lw/lh → WAIT with counter = RD_WAIT−1; sw → ACT (no read needed); illegal → DONE with err latched 1.
  - `start`=0: stay in IDLE.
- WAIT: counter decrements each cycle; at 0 → CAPT.
- CAPT: `mem_q` ← `mem_rdata`; → ACT.
- ACT:
  - Loads: `mdr` ← `sh_out`; `mem_wr`=0.
  - Stores: `mem_wr`=1, `mem_wdata`=`sh_out`.
  - → DONE.
- DONE: `done`=1, `err` as latched; → IDLE. `start` ignored outside IDLE (not queued).
- `mem_wr` is decoded from state: high only in ACT with a store op. Exactly one write per store request; never any write for loads or illegal ops.
- `mem_addr`, `sh_sel`, `B_q` hold their latched values until the next accepted start.
- `mdr` changes only in ACT for loads.
- `mem_q` changes only in CAPT. It is stale for sw, which the size handler ignores.
- `err` clears on the next accepted start.

## Timing
- Reset (synchronous):
  - State → IDLE; counter 0.
  - `mem_addr`, `mem_q`, `B_q`, `mdr` = 0; `sh_sel` = 000.
  - `mem_wr`, `busy`, `done`, `err` = 0.
- Reset overrides `start` in the same cycle.
- Reset asserted mid-operation aborts the operation: no later write, `done` not pulsed.
- A write already decoded in the ACT cycle in which reset is sampled is still presented to memory for that cycle.
- Cycle numbering below has `start` accepted at cycle 0. `mem_addr` is valid from cycle 1.
- Read-type ops (lb/lh/lw/sb/sh):
  - WAIT: cycles 1..RD_WAIT.
  - CAPT: cycle RD_WAIT+1; memory data is valid here.
  - ACT: cycle RD_WAIT+2.
  - DONE: cycle RD_WAIT+3.
  - RD_WAIT=2 → done at cycle 5.
- sw: ACT at cycle 1, done at cycle 2.
- Illegal op: done+err at cycle 1.
- Back-to-back: next `start` is accepted at the earliest in the IDLE cycle following DONE.
- `mdr` is updated at the ACT→DONE edge, so it is valid when `done`=1.

## Test plan
- lw, addr 0x10, memory word 0x11223344, RD_WAIT=2, sh_out modelled as byte reversal → `busy` cycles 1-4, `done` cycle 5, `mdr`=0x44332211, `mem_wr` never high.
- sw, addr 0x20, B=0xAABBCCDD → `mem_wr`=1 only in cycle 1 with `mem_addr`=0x20 and `mem_wdata`=`sh_out`, `done` cycle 2, `mdr` unchanged.
- sb, memory 0x11223344, B=0x000000EE → exactly one write in cycle 4 with `mem_wdata`=`sh_out` computed from `mem_q`=0x11223344 and `sh_sel`=000; `done` cycle 5.
- op=111 → `done`=1 and `err`=1 in cycle 1, no `mem_wr`, `busy` never high; a following lw clears `err`.
- reset asserted in cycle 3 of an sh → state IDLE in cycle 4, all outputs at reset values, no write ever issued, no `done`.
- `start` held high continuously with lh, RD_WAIT=1 → requests accepted at cycles 0, 5, 10 …; `done` at cycles 4, 9, …; no start accepted while `busy` or `done`.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: presents the address, waits out the read latency,
// captures the memory word, then either loads the size-handler result or issues the merged write.
//
// state | meaning
// IDLE  | waiting for start; request fields latched on acceptance
// WAIT  | counting down the memory read latency
// CAPT  | memory word valid, registered into mem_q
// ACT   | load: mdr <= sh_out; store: mem_wr asserted for this cycle
// DONE  | one-cycle done pulse (err reflects an illegal op)
module mem_access_ctrl #(
    parameter int RD_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] B,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] sh_out,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_q,
    output logic [31:0] B_q,
    output logic [2:0]  sh_sel,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        CAPT = 3'd2,
        ACT  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT - 1);

    state_t     state;
    logic [3:0] cnt;

    function automatic logic is_store(input logic [2:0] o);
        return (o == 3'b000) || (o == 3'b001) || (o == 3'b010);
    endfunction

    assign mem_wdata = sh_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            mem_addr <= 32'd0;
            mem_q    <= 32'd0;
            B_q      <= 32'd0;
            mdr      <= 32'd0;
            sh_sel   <= 3'b000;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_sel   <= op;
                        mem_addr <= addr;
                        B_q      <= B;
                        err      <= 1'b0;
                        case (op)
                            3'b001: begin
                                // sw needs no read: straight to the write cycle
                                state  <= ACT;
                                busy   <= 1'b1;
                                mem_wr <= 1'b1;
                            end
                            3'b000, 3'b010, 3'b011, 3'b100, 3'b101: begin
                                state <= WAIT;
                                cnt   <= WAIT_INIT;
                                busy  <= 1'b1;
                            end
                            default: begin
                                state <= DONE;
                                err   <= 1'b1;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= CAPT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPT: begin
                    mem_q  <= mem_rdata;
                    mem_wr <= is_store(sh_sel);
                    state  <= ACT;
                end
                ACT: begin
                    if (!is_store(sh_sel)) begin
                        mdr <= sh_out;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model
// (latency per op type, memory array, behavioural size handler).
module tb_mem_access_ctrl;

    localparam int RDW = 2;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] addr, B, mem_rdata, sh_out;
    logic [31:0] mem_addr, mem_wdata, mem_q, B_q, mdr;
    logic        mem_wr, busy, done, err;
    logic [2:0]  sh_sel;

    always #5 clk = ~clk;

    mem_access_ctrl #(.RD_WAIT(RDW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .B(B),
        .mem_rdata(mem_rdata), .sh_out(sh_out), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_q(mem_q), .B_q(B_q), .sh_sel(sh_sel), .mdr(mdr),
        .busy(busy), .done(done), .err(err)
    );

    // size handler: stores merge B into the memory word, loads extend; lw byte-reverses
    function automatic logic [31:0] sh_fn(input logic [2:0] sel, input logic [31:0] m,
                                          input logic [31:0] b);
        case (sel)
            3'b000:  return {m[31:8], b[7:0]};
            3'b001:  return b;
            3'b010:  return {m[31:16], b[15:0]};
            3'b011:  return {{24{m[7]}}, m[7:0]};
            3'b100:  return {m[7:0], m[15:8], m[23:16], m[31:24]};
            3'b101:  return {{16{m[15]}}, m[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    assign sh_out = sh_fn(sh_sel, mem_q, B_q);

    function automatic bit is_store(input logic [2:0] o);
        return o <= 3'd2;
    endfunction
    function automatic bit is_read(input logic [2:0] o);
        return (o <= 3'd5) && (o != 3'd1);
    endfunction
    function automatic bit is_load(input logic [2:0] o);
        return (o >= 3'd3) && (o <= 3'd5);
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [31:0] mem [16];

    bit          m_valid = 0;
    bit          m_act = 0;
    int          m_t = 0;
    int          m_len = 0;
    logic [2:0]  m_op = 3'd0;
    logic [31:0] m_addr = 0, m_b = 0, e_mem_q = 0, e_mdr = 0;
    logic        m_err = 0;
    int          done_cnt = 0;

    task automatic step(input logic rst, input logic st, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
        logic e_busy, e_done, e_wr;
        @(negedge clk);
        e_busy = m_act && (m_t < m_len);
        e_done = m_act && (m_t == m_len);
        e_wr   = m_act && is_store(m_op) && (m_t == m_len - 1);
        if (m_valid) begin
            check_val("busy", {31'd0, busy}, {31'd0, e_busy});
            check_val("done", {31'd0, done}, {31'd0, e_done});
            check_val("err", {31'd0, err}, {31'd0, m_err});
            check_val("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
            check_val("mem_addr", mem_addr, m_addr);
            check_val("sh_sel", {29'd0, sh_sel}, {29'd0, m_op});
            check_val("B_q", B_q, m_b);
            check_val("mem_q", mem_q, e_mem_q);
            check_val("mdr", mdr, e_mdr);
            if (e_wr) check_val("mem_wdata", mem_wdata, sh_fn(m_op, e_mem_q, m_b));
        end
        if (done === 1'b1) done_cnt++;
        if (e_wr) mem[m_addr[5:2]] = sh_fn(m_op, e_mem_q, m_b);

        reset = rst; start = st; op = o; addr = a; B = b;
        mem_rdata = (m_act && is_read(m_op) && m_t == RDW + 1) ? mem[m_addr[5:2]] : $urandom;

        if (rst) begin
            m_valid = 1; m_act = 0; m_t = 0; m_len = 0; m_op = 3'd0;
            m_addr = 0; m_b = 0; e_mem_q = 0; e_mdr = 0; m_err = 0;
        end else if (m_act) begin
            if (is_read(m_op) && m_t == RDW + 1) e_mem_q = mem_rdata;
            if (is_load(m_op) && m_t == m_len - 1) e_mdr = sh_fn(m_op, e_mem_q, m_b);
            if (m_t == m_len) m_act = 0;
            else m_t++;
        end else if (st) begin
            m_act = 1; m_t = 1; m_op = o; m_addr = a; m_b = b;
            m_err = (o >= 3'd6);
            m_len = (o >= 3'd6) ? 1 : (o == 3'd1) ? 2 : RDW + 3;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        reset = 1'b1; start = 1'b0; op = 3'd0; addr = 0; B = 0; mem_rdata = 0;
        step(1'b1, 1'b0, 3'd0, 0, 0);
        step(1'b1, 1'b0, 3'd0, 0, 0);
        idle(2);

        // lw 0x10, word 0x11223344 -> byte-reversed into mdr at cycle 5
        mem[4] = 32'h11223344;
        step(1'b0, 1'b1, 3'd4, 32'h10, 32'h0);
        idle(5);
        check_val("lw_done_c5", {31'd0, done}, 32'd1);
        check_val("lw_mdr", mdr, 32'h44332211);

        // sw 0x20: write in cycle 1, done cycle 2
        step(1'b0, 1'b1, 3'd1, 32'h20, 32'hAABBCCDD);
        idle(1);
        check_val("sw_wr_c1", {31'd0, mem_wr}, 32'd1);
        check_val("sw_addr", mem_addr, 32'h20);
        check_val("sw_wdata", mem_wdata, 32'hAABBCCDD);
        idle(1);
        check_val("sw_done_c2", {31'd0, done}, 32'd1);
        check_val("sw_mdr_kept", mdr, 32'h44332211);

        // sb merge into 0x11223344: write in cycle 4
        mem[12] = 32'h11223344;
        step(1'b0, 1'b1, 3'd0, 32'h30, 32'h000000EE);
        idle(4);
        check_val("sb_wr_c4", {31'd0, mem_wr}, 32'd1);
        check_val("sb_wdata", mem_wdata, 32'h112233EE);
        idle(1);
        check_val("sb_done_c5", {31'd0, done}, 32'd1);

        // illegal op then lw clears err
        step(1'b0, 1'b1, 3'd7, 32'h44, 32'h5);
        idle(1);
        check_val("ill_done", {31'd0, done}, 32'd1);
        check_val("ill_err", {31'd0, err}, 32'd1);
        check_val("ill_busy", {31'd0, busy}, 32'd0);
        idle(1);
        step(1'b0, 1'b1, 3'd4, 32'h8, 32'h0);
        idle(1);
        check_val("err_cleared", {31'd0, err}, 32'd0);
        idle(6);

        // reset in cycle 3 of an sh
        step(1'b0, 1'b1, 3'd2, 32'h34, 32'h1234);
        idle(2);
        step(1'b1, 1'b0, 3'd0, 0, 0);
        idle(1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        done_cnt = 0;
        idle(8);
        check_val("rst_no_done", done_cnt, 32'd0);

        // start held high with lh: accepted at 0,6,12,18 -> done at 5,11,17
        done_cnt = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'd5, 32'h0C, 32'h0);
        check_val("lh_b2b_dones", done_cnt, 32'd3);
        idle(8);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 60) == 0, ($urandom % 3) != 0, 3'($urandom % 8),
                 $urandom, $urandom);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
